// File: rtl/scope_cmd_ctrl.sv
// UART command decoder for the scope trigger: arm/stop and 10-byte trigger payloads; one response byte per command.
// Responses take effect one cycle after rx_valid and hold until tx_ready; optional SCOPE_CMD_TIMEOUT_EN aborts a stalled payload.
module scope_cmd_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  output logic [39:0] trig_value,
  output logic [39:0] trig_mask,
  output logic        trig_edge,
  output logic        arm,
  input  logic        capture_done,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, PAYLOAD, RESP} state_t;

  localparam logic [7:0] CH_K = 8'h4B;
  localparam logic [7:0] CH_E = 8'h45;
  localparam logic [7:0] CH_B = 8'h42;
  localparam logic [7:0] CH_D = 8'h44;

  state_t      state, state_nxt;
  logic        arm_nxt;
  logic        tx_valid_nxt;
  logic [7:0]  tx_data_nxt;
  logic [39:0] trig_value_nxt, trig_mask_nxt;
  logic        trig_edge_nxt;
  logic        done_pend, done_pend_nxt;
  logic [3:0]  byte_cnt, byte_cnt_nxt;
  logic [71:0] shadow, shadow_nxt;
  logic        edge_lat, edge_lat_nxt;
  logic        reject, reject_nxt;

`ifdef SCOPE_CMD_TIMEOUT_EN
  localparam logic [19:0] TMO_LAST = 20'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]  CH_T     = 8'h54;
  logic [19:0] tmo_cnt, tmo_cnt_nxt;

  // Counts idle cycles since the last payload byte; zero outside PAYLOAD.
  always_comb begin
    tmo_cnt_nxt = 20'd0;
    if (state == PAYLOAD && !rx_valid)
      tmo_cnt_nxt = tmo_cnt + 20'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tmo_cnt <= 20'd0;
    else        tmo_cnt <= tmo_cnt_nxt;
  end
`else
  logic unused_timeout_param;
  assign unused_timeout_param = (TIMEOUT_CYCLES != 0);
`endif

  always_comb begin
    state_nxt      = state;
    arm_nxt        = arm;
    tx_valid_nxt   = tx_valid;
    tx_data_nxt    = tx_data;
    trig_value_nxt = trig_value;
    trig_mask_nxt  = trig_mask;
    trig_edge_nxt  = trig_edge;
    done_pend_nxt  = done_pend;
    byte_cnt_nxt   = byte_cnt;
    shadow_nxt     = shadow;
    edge_lat_nxt   = edge_lat;
    reject_nxt     = reject;

    case (state)
      IDLE: begin
        if (rx_valid) begin
          state_nxt = RESP;
          tx_valid_nxt = 1'b1;
          case (rx_data)
            8'h41: begin arm_nxt = 1'b1; tx_data_nxt = CH_K; end
            8'h53: begin arm_nxt = 1'b0; tx_data_nxt = CH_K; end
            8'h52, 8'h46: begin
              // Payload commands respond only after the tenth byte.
              state_nxt    = PAYLOAD;
              tx_valid_nxt = 1'b0;
              edge_lat_nxt = (rx_data == 8'h52);
              reject_nxt   = arm;
              byte_cnt_nxt = 4'd0;
            end
            default: tx_data_nxt = CH_E;
          endcase
        end else if (done_pend) begin
          state_nxt     = RESP;
          tx_valid_nxt  = 1'b1;
          tx_data_nxt   = CH_D;
          done_pend_nxt = 1'b0;
        end
      end
      PAYLOAD: begin
        if (rx_valid) begin
          if (byte_cnt == 4'd9) begin
            if (!reject) begin
              {trig_value_nxt, trig_mask_nxt} = {shadow, rx_data};
              trig_edge_nxt = edge_lat;
            end
            state_nxt    = RESP;
            tx_valid_nxt = 1'b1;
            tx_data_nxt  = reject ? CH_B : CH_K;
          end else begin
            shadow_nxt   = {shadow[63:0], rx_data};
            byte_cnt_nxt = byte_cnt + 4'd1;
          end
        end
`ifdef SCOPE_CMD_TIMEOUT_EN
        else if (tmo_cnt == TMO_LAST) begin
          state_nxt    = RESP;
          tx_valid_nxt = 1'b1;
          tx_data_nxt  = CH_T;
        end
`endif
      end
      RESP: begin
        if (tx_ready) begin
          state_nxt    = IDLE;
          tx_valid_nxt = 1'b0;
        end
      end
      default: state_nxt = IDLE;
    endcase

    // Evaluated last so a capture is never lost to a same-cycle 'D' send.
    if (capture_done && arm) begin
      arm_nxt       = 1'b0;
      done_pend_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      arm        <= 1'b0;
      tx_valid   <= 1'b0;
      tx_data    <= 8'h00;
      trig_value <= 40'd0;
      trig_mask  <= 40'd0;
      trig_edge  <= 1'b1;
      done_pend  <= 1'b0;
      byte_cnt   <= 4'd0;
      shadow     <= 72'd0;
      edge_lat   <= 1'b1;
      reject     <= 1'b0;
    end else begin
      state      <= state_nxt;
      arm        <= arm_nxt;
      tx_valid   <= tx_valid_nxt;
      tx_data    <= tx_data_nxt;
      trig_value <= trig_value_nxt;
      trig_mask  <= trig_mask_nxt;
      trig_edge  <= trig_edge_nxt;
      done_pend  <= done_pend_nxt;
      byte_cnt   <= byte_cnt_nxt;
      shadow     <= shadow_nxt;
      edge_lat   <= edge_lat_nxt;
      reject     <= reject_nxt;
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_scope_cmd_ctrl.sv
// Directed bench for scope_cmd_ctrl; inputs driven on the falling edge, outputs sampled on the falling edge.
module tb_scope_cmd_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready = 1'b1;
  logic [39:0] trig_value;
  logic [39:0] trig_mask;
  logic        trig_edge;
  logic        arm;
  logic        capture_done = 1'b0;
  logic        busy;

  int nchk = 0;
  int nfail = 0;

  scope_cmd_ctrl #(.TIMEOUT_CYCLES(100)) dut (
    .clk(clk), .rst_n(rst_n), .rx_valid(rx_valid), .rx_data(rx_data),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .trig_value(trig_value), .trig_mask(trig_mask), .trig_edge(trig_edge),
    .arm(arm), .capture_done(capture_done), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 200 && busy; i++) @(negedge clk);
  endtask

  task automatic send_cmd(input logic [7:0] b);
    wait_idle();
    send_byte(b);
  endtask

  // Waits for the next response byte; returns X data if none arrives in time.
  task automatic wait_tx(input int limit, output int n, output logic [7:0] d);
    n = 0;
    while (tx_valid && n < limit) begin @(negedge clk); n++; end
    while (!tx_valid && n < limit) begin @(negedge clk); n++; end
    d = tx_valid ? tx_data : 8'hxx;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    nchk++; if ({arm, tx_valid, tx_data, busy} !== 11'd0) begin nfail++;
      $display("FAIL reset_ctl: got arm=%b txv=%b txd=%h busy=%b exp all 0", arm, tx_valid, tx_data, busy); end
    nchk++; if ({trig_value, trig_mask, trig_edge} !== {80'd0, 1'b1}) begin nfail++;
      $display("FAIL reset_trig: got v=%h m=%h e=%b exp 0 0 1", trig_value, trig_mask, trig_edge); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_arm_capture();
    int n; logic [7:0] d;
    send_cmd(8'h41);
    nchk++; if ({arm, tx_valid, tx_data} !== {1'b1, 1'b1, 8'h4B}) begin nfail++;
      $display("FAIL arm_resp: got arm=%b txv=%b txd=%h exp 1 1 4b", arm, tx_valid, tx_data); end
    wait_idle();
    @(negedge clk); capture_done = 1'b1;
    @(negedge clk); capture_done = 1'b0;
    nchk++; if (arm !== 1'b0) begin nfail++;
      $display("FAIL capture_arm: got %b exp 0", arm); end
    wait_tx(20, n, d);
    nchk++; if (d !== 8'h44) begin nfail++;
      $display("FAIL capture_d: got %h exp 44", d); end
    // Capture while disarmed must not produce another 'D'.
    wait_idle();
    @(negedge clk); capture_done = 1'b1;
    @(negedge clk); capture_done = 1'b0;
    repeat (5) @(negedge clk);
    nchk++; if ({tx_valid, busy} !== 2'b00) begin nfail++;
      $display("FAIL capture_ignored: got txv=%b busy=%b exp 0 0", tx_valid, busy); end
  endtask

  task automatic test_payload();
    logic [7:0] rbytes [10] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'hFF};
    logic [7:0] fbytes [10] = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hF0, 8'h0F, 8'hAA, 8'h55, 8'h01};
    send_cmd(8'h52);
    for (int i = 0; i < 9; i++) send_byte(rbytes[i]);
    nchk++; if ({busy, tx_valid, trig_value, trig_mask} !== {1'b1, 1'b0, 80'd0}) begin nfail++;
      $display("FAIL payload_partial: got busy=%b txv=%b v=%h m=%h exp 1 0 0 0", busy, tx_valid, trig_value, trig_mask); end
    send_byte(rbytes[9]);
    nchk++; if ({trig_value, trig_mask, trig_edge, tx_valid, tx_data} !== {40'h0000000001, 40'h00000000FF, 1'b1, 1'b1, 8'h4B}) begin nfail++;
      $display("FAIL payload_r: got v=%h m=%h e=%b txv=%b txd=%h exp 0000000001 00000000ff 1 1 4b",
               trig_value, trig_mask, trig_edge, tx_valid, tx_data); end
    send_cmd(8'h46);
    for (int i = 0; i < 10; i++) send_byte(fbytes[i]);
    nchk++; if ({trig_value, trig_mask, trig_edge, tx_data} !== {40'h123456789A, 40'hF00FAA5501, 1'b0, 8'h4B}) begin nfail++;
      $display("FAIL payload_f: got v=%h m=%h e=%b txd=%h exp 123456789a f00faa5501 0 4b",
               trig_value, trig_mask, trig_edge, tx_data); end
  endtask

  task automatic test_reject_while_armed();
    send_cmd(8'h41);
    send_cmd(8'h52);
    for (int i = 0; i < 10; i++) send_byte(8'hAA);
    nchk++; if ({trig_value, trig_mask, trig_edge, arm} !== {40'h123456789A, 40'hF00FAA5501, 1'b0, 1'b1}) begin nfail++;
      $display("FAIL reject_regs: got v=%h m=%h e=%b arm=%b exp 123456789a f00faa5501 0 1",
               trig_value, trig_mask, trig_edge, arm); end
    nchk++; if ({tx_valid, tx_data} !== {1'b1, 8'h42}) begin nfail++;
      $display("FAIL reject_resp: got txv=%b txd=%h exp 1 42", tx_valid, tx_data); end
    send_cmd(8'h41);
    nchk++; if ({arm, tx_data} !== {1'b1, 8'h4B}) begin nfail++;
      $display("FAIL rearm: got arm=%b txd=%h exp 1 4b", arm, tx_data); end
    send_cmd(8'h5A);
    nchk++; if ({arm, tx_valid, tx_data} !== {1'b1, 1'b1, 8'h45}) begin nfail++;
      $display("FAIL unknown_op: got arm=%b txv=%b txd=%h exp 1 1 45", arm, tx_valid, tx_data); end
  endtask

  task automatic test_stop_with_capture();
    int n; logic [7:0] d;
    wait_idle();
    @(negedge clk); rx_valid = 1'b1; rx_data = 8'h53; capture_done = 1'b1;
    @(negedge clk); rx_valid = 1'b0; capture_done = 1'b0;
    nchk++; if ({arm, tx_valid, tx_data} !== {1'b0, 1'b1, 8'h4B}) begin nfail++;
      $display("FAIL stop_cap_k: got arm=%b txv=%b txd=%h exp 0 1 4b", arm, tx_valid, tx_data); end
    wait_tx(20, n, d);
    nchk++; if (d !== 8'h44) begin nfail++;
      $display("FAIL stop_cap_d: got %h exp 44", d); end
  endtask

  task automatic test_byte_wins();
    int n; logic [7:0] d;
    send_cmd(8'h41);
    wait_idle();
    @(negedge clk); capture_done = 1'b1;
    @(negedge clk); capture_done = 1'b0; rx_valid = 1'b1; rx_data = 8'h5A;
    @(negedge clk); rx_valid = 1'b0;
    nchk++; if ({tx_valid, tx_data} !== {1'b1, 8'h45}) begin nfail++;
      $display("FAIL byte_wins_e: got txv=%b txd=%h exp 1 45", tx_valid, tx_data); end
    wait_tx(20, n, d);
    nchk++; if (d !== 8'h44) begin nfail++;
      $display("FAIL byte_wins_d: got %h exp 44", d); end
  endtask

  task automatic test_backpressure();
    logic stable = 1'b1;
    wait_idle();
    tx_ready = 1'b0;
    send_byte(8'h53);
    for (int i = 0; i < 50; i++) begin
      if (i == 20) begin rx_valid = 1'b1; rx_data = 8'h41; end
      if (i == 21) rx_valid = 1'b0;
      if ({tx_valid, tx_data} !== {1'b1, 8'h4B}) stable = 1'b0;
      @(negedge clk);
    end
    nchk++; if (stable !== 1'b1) begin nfail++;
      $display("FAIL bp_stable: got stable=%b exp 1", stable); end
    nchk++; if ({tx_valid, tx_data, arm} !== {1'b1, 8'h4B, 1'b0}) begin nfail++;
      $display("FAIL bp_hold: got txv=%b txd=%h arm=%b exp 1 4b 0", tx_valid, tx_data, arm); end
    tx_ready = 1'b1;
    @(negedge clk);
    nchk++; if ({tx_valid, busy} !== 2'b00) begin nfail++;
      $display("FAIL bp_release: got txv=%b busy=%b exp 0 0", tx_valid, busy); end
  endtask

  task automatic test_timeout();
    int n; logic [7:0] d;
    send_cmd(8'h52);
    for (int i = 0; i < 3; i++) send_byte(8'h77);
`ifdef SCOPE_CMD_TIMEOUT_EN
    wait_tx(300, n, d);
    nchk++; if ({d, n} !== {8'h54, 32'd100}) begin nfail++;
      $display("FAIL timeout_t: got txd=%h after %0d cycles exp 54 after 100", d, n); end
    nchk++; if ({trig_value, trig_mask} !== {40'h123456789A, 40'hF00FAA5501}) begin nfail++;
      $display("FAIL timeout_regs: got v=%h m=%h exp unchanged", trig_value, trig_mask); end
`else
    wait_tx(150, n, d);
    nchk++; if ({busy, tx_valid} !== 2'b10) begin nfail++;
      $display("FAIL no_timeout: got busy=%b txv=%b exp 1 0", busy, tx_valid); end
`endif
  endtask

  task automatic test_reset_mid_payload();
    send_cmd(8'h46);
    for (int i = 0; i < 4; i++) send_byte(8'h33);
    #2 rst_n = 1'b0;
    #1;
    nchk++; if ({arm, tx_valid, tx_data, busy, trig_value, trig_mask, trig_edge} !== {11'd0, 80'd0, 1'b1}) begin nfail++;
      $display("FAIL reset_mid: got arm=%b txv=%b txd=%h busy=%b v=%h m=%h e=%b exp reset values",
               arm, tx_valid, tx_data, busy, trig_value, trig_mask, trig_edge); end
    @(negedge clk); rst_n = 1'b1;
    send_cmd(8'h41);
    nchk++; if ({arm, tx_valid, tx_data} !== {1'b1, 1'b1, 8'h4B}) begin nfail++;
      $display("FAIL after_reset: got arm=%b txv=%b txd=%h exp 1 1 4b", arm, tx_valid, tx_data); end
  endtask

  initial begin
    test_reset();
    test_arm_capture();
    test_payload();
    test_reject_while_armed();
    test_stop_with_capture();
    test_byte_wins();
    test_backpressure();
    test_timeout();
    test_reset_mid_payload();
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule
